waveform_sequencer: RTL and testbench

- Controller that drives the six configuration words of the DDS modulator from a small on-chip table of waveform profiles.
- The processor writes up to NUM_PROFILES profiles, then issues start. The block applies each profile for a programmed dwell time and inserts a short enable-low gap between profiles so the modulator counters and the DDS resynchronise. It then advances to the next profile, stops at the end or loops.
- Sits between the AXI-Lite register bank and the modulator's config_reg_0..5 inputs.

---
 rtl/dds_modulator_pkg.sv | 13 +
 rtl/waveform_sequencer_profile_table.sv | 49 ++++
 rtl/waveform_sequencer.sv | 168 ++++++++++++++++
 tb/tb_waveform_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_modulator_pkg.sv
// dds_modulator_pkg: shared constants and types for the DDS modulator and its waveform sequencer.
// No ports; provides the config-word bit positions, the profile table layout and the sequencer state type.
package dds_modulator_pkg;

    localparam int ENABLE_BIT = 0;
    localparam int DEBUG_BIT  = 1;

    localparam int PROF_WORDS = 7;
    localparam int DWELL_WORD = 6;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, DONE} seq_state_t;

endpackage

// File: rtl/waveform_sequencer_profile_table.sv
// waveform_sequencer_profile_table: register file holding NUM_PROFILES profiles of PROF_WORDS 32-bit words.
// Ports:
//   clk_i, resetn_i  clock and asynchronous active-low reset (clears every word)
//   wr_en_i          write strobe
//   wr_addr_i        {profile index, word index}; word index 7 is ignored
//   wr_data_i        write data
//   prot_en_i        when high, writes to profile prot_idx_i are dropped
//   prot_idx_i       protected (active) profile index
//   rd_idx_i         profile read index
//   rd_prof_o        combinational read of the full profile, word 0 in the low bits
//   wr_drop_o        high in the cycle a write is dropped by the protection
module waveform_sequencer_profile_table
    import dds_modulator_pkg::*;
#(
    parameter  int NUM_PROFILES = 4,
    localparam int AW           = $clog2(NUM_PROFILES)
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic                       wr_en_i,
    input  logic [AW+2:0]              wr_addr_i,
    input  logic [31:0]                wr_data_i,
    input  logic                       prot_en_i,
    input  logic [AW-1:0]              prot_idx_i,
    input  logic [AW-1:0]              rd_idx_i,
    output logic [PROF_WORDS*32-1:0]   rd_prof_o,
    output logic                       wr_drop_o
);

    logic [PROF_WORDS-1:0][31:0] mem_q [NUM_PROFILES];
    logic [2:0]                  wr_word;
    logic [AW-1:0]               wr_prof;
    logic                        wr_hit;

    assign wr_word   = wr_addr_i[2:0];
    assign wr_prof   = wr_addr_i[AW+2:3];
    assign wr_hit    = wr_en_i && (wr_word != 3'd7);
    assign wr_drop_o = wr_hit && prot_en_i && (wr_prof == prot_idx_i);
    assign rd_prof_o = mem_q[rd_idx_i];

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < NUM_PROFILES; i++) mem_q[i] <= '0;
        end else if (wr_hit && !wr_drop_o) begin
            mem_q[wr_prof][wr_word] <= wr_data_i;
        end
    end

endmodule

// File: rtl/waveform_sequencer.sv
// waveform_sequencer: steps the DDS modulator through a table of profiles, each held for its dwell time,
// with an enable-low gap between profiles.
// Ports:
//   clk_i, resetn_i                  clock and asynchronous active-low reset
//   prof_wr_en_i/addr_i/data_i       profile table write port ({profile, word} address)
//   start_i, stop_i                  start and abort pulses (stop wins)
//   loop_i, num_profiles_i           sequence options, sampled on an accepted start
//   config_reg_0_o..config_reg_5_o   registered modulator configuration words
//   busy_o                           high in LOAD, RUN and GAP
//   active_profile_o                 index of the applied profile
//   seq_done_o                       one-cycle pulse when a non-looping sequence completes
//   wr_err_o                         sticky: a write hit the active profile while busy
module waveform_sequencer
    import dds_modulator_pkg::*;
#(
    parameter  int NUM_PROFILES = 4,
    parameter  int DWELL_BITS   = 32,
    parameter  int GAP_CYCLES   = 4,
    localparam int AW           = $clog2(NUM_PROFILES),
    localparam int CW           = AW + 1,
    localparam int GW           = $clog2(GAP_CYCLES + 1)
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          prof_wr_en_i,
    input  logic [AW+2:0] prof_wr_addr_i,
    input  logic [31:0]   prof_wr_data_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          loop_i,
    input  logic [CW-1:0] num_profiles_i,
    output logic [31:0]   config_reg_0_o,
    output logic [31:0]   config_reg_1_o,
    output logic [31:0]   config_reg_2_o,
    output logic [31:0]   config_reg_3_o,
    output logic [31:0]   config_reg_4_o,
    output logic [31:0]   config_reg_5_o,
    output logic          busy_o,
    output logic [AW-1:0] active_profile_o,
    output logic          seq_done_o,
    output logic          wr_err_o
);

    seq_state_t                  state_q, state_d;
    logic [AW-1:0]               idx_q, idx_d, act_q, act_d;
    logic [CW-1:0]               n_q, n_d;
    logic                        loop_q, loop_d, done_q, done_d, busy_q, busy_d, err_q, err_d;
    logic [DWELL_BITS-1:0]       dwell_q, dwell_d, dwell_ld;
    logic [GW-1:0]               gap_q, gap_d;
    logic [5:0][31:0]            cfg_q, cfg_d;
    logic [PROF_WORDS*32-1:0]    prof;
    logic                        wr_drop, last;

    waveform_sequencer_profile_table #(
        .NUM_PROFILES (NUM_PROFILES)
    ) u_table (
        .clk_i      (clk_i),
        .resetn_i   (resetn_i),
        .wr_en_i    (prof_wr_en_i),
        .wr_addr_i  (prof_wr_addr_i),
        .wr_data_i  (prof_wr_data_i),
        .prot_en_i  (busy_q),
        .prot_idx_i (idx_q),
        .rd_idx_i   (idx_q),
        .rd_prof_o  (prof),
        .wr_drop_o  (wr_drop)
    );

    assign dwell_ld = prof[DWELL_WORD*32 +: DWELL_BITS];
    // index = n-1, computed one bit wider so n = NUM_PROFILES compares correctly
    assign last     = ({1'b0, idx_q} + CW'(1)) >= n_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        loop_d  = loop_q;
        dwell_d = dwell_q;
        gap_d   = gap_q;
        cfg_d   = cfg_q;
        act_d   = act_q;
        done_d  = 1'b0;
        err_d   = err_q | wr_drop;
        case (state_q)
            IDLE: if (start_i && num_profiles_i != '0) begin
                state_d = LOAD;
                idx_d   = '0;
                loop_d  = loop_i;
                n_d     = (num_profiles_i > CW'(NUM_PROFILES)) ? CW'(NUM_PROFILES) : num_profiles_i;
                err_d   = 1'b0;
            end
            LOAD: begin
                state_d               = RUN;
                cfg_d                 = prof[6*32-1:0];
                cfg_d[0][ENABLE_BIT]  = 1'b1;
                dwell_d               = (dwell_ld == '0) ? DWELL_BITS'(1) : dwell_ld;
                act_d                 = idx_q;
            end
            RUN: if (dwell_q <= DWELL_BITS'(1)) begin
                state_d              = GAP;
                gap_d                = GW'(GAP_CYCLES);
                cfg_d[0][ENABLE_BIT] = 1'b0;
            end else begin
                dwell_d = dwell_q - DWELL_BITS'(1);
            end
            GAP: if (gap_q <= GW'(1)) begin
                if (!last || loop_q) begin
                    state_d = LOAD;
                    idx_d   = last ? '0 : idx_q + AW'(1);
                end else begin
                    state_d = DONE;
                    cfg_d   = '0;
                    done_d  = 1'b1;
                end
            end else begin
                gap_d = gap_q - GW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (stop_i) begin
            state_d = IDLE;
            cfg_d   = '0;
            done_d  = 1'b0;
        end
        busy_d = (state_d == LOAD) || (state_d == RUN) || (state_d == GAP);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            loop_q  <= 1'b0;
            dwell_q <= '0;
            gap_q   <= '0;
            cfg_q   <= '0;
            act_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            loop_q  <= loop_d;
            dwell_q <= dwell_d;
            gap_q   <= gap_d;
            cfg_q   <= cfg_d;
            act_q   <= act_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign config_reg_0_o   = cfg_q[0];
    assign config_reg_1_o   = cfg_q[1];
    assign config_reg_2_o   = cfg_q[2];
    assign config_reg_3_o   = cfg_q[3];
    assign config_reg_4_o   = cfg_q[4];
    assign config_reg_5_o   = cfg_q[5];
    assign busy_o           = busy_q;
    assign active_profile_o = act_q;
    assign seq_done_o       = done_q;
    assign wr_err_o         = err_q;

endmodule

// File: tb/tb_waveform_sequencer.sv
// tb_waveform_sequencer: table-driven, scoreboarded bench for waveform_sequencer.
module tb_waveform_sequencer;
    import dds_modulator_pkg::*;

    localparam int NP  = 4;
    localparam int GAP = 4;

    typedef logic [5:0][31:0] cfg_t;
    typedef struct packed {
        cfg_t       cfg;
        logic       busy;
        logic       done;
        logic [1:0] act;
    } exp_t;
    typedef struct {
        int n;
        bit lp;
        int stop_at;
        int d0, d1, d2, d3;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        prof_wr_en_i;
    logic [4:0]  prof_wr_addr_i;
    logic [31:0] prof_wr_data_i;
    logic        start_i, stop_i, loop_i;
    logic [2:0]  num_profiles_i;
    logic [31:0] config_reg_0_o, config_reg_1_o, config_reg_2_o;
    logic [31:0] config_reg_3_o, config_reg_4_o, config_reg_5_o;
    logic        busy_o, seq_done_o, wr_err_o;
    logic [1:0]  active_profile_o;

    int          vecs = 0;
    int          bad  = 0;
    logic [31:0] tbl [NP][7];
    logic [1:0]  act_now;
    exp_t        sb [$];
    vec_t        vt [7];

    waveform_sequencer #(
        .NUM_PROFILES (NP),
        .DWELL_BITS   (32),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk_i            (clk_i),
        .resetn_i         (resetn_i),
        .prof_wr_en_i     (prof_wr_en_i),
        .prof_wr_addr_i   (prof_wr_addr_i),
        .prof_wr_data_i   (prof_wr_data_i),
        .start_i          (start_i),
        .stop_i           (stop_i),
        .loop_i           (loop_i),
        .num_profiles_i   (num_profiles_i),
        .config_reg_0_o   (config_reg_0_o),
        .config_reg_1_o   (config_reg_1_o),
        .config_reg_2_o   (config_reg_2_o),
        .config_reg_3_o   (config_reg_3_o),
        .config_reg_4_o   (config_reg_4_o),
        .config_reg_5_o   (config_reg_5_o),
        .busy_o           (busy_o),
        .active_profile_o (active_profile_o),
        .seq_done_o       (seq_done_o),
        .wr_err_o         (wr_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t obs();
        exp_t o;
        o.cfg  = {config_reg_5_o, config_reg_4_o, config_reg_3_o, config_reg_2_o, config_reg_1_o, config_reg_0_o};
        o.busy = busy_o;
        o.done = seq_done_o;
        o.act  = active_profile_o;
        return o;
    endfunction

    function automatic cfg_t prof_cfg(input int p);
        cfg_t c;
        for (int w = 0; w < 6; w++) c[w] = tbl[p][w];
        c[0][ENABLE_BIT] = 1'b1;
        return c;
    endfunction

    task automatic chk(input string name, input exp_t got, input exp_t exp);
        vecs++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wr(input int p, input int w, input logic [31:0] d);
        prof_wr_en_i   = 1'b1;
        prof_wr_addr_i = {2'(p), 3'(w)};
        prof_wr_data_i = d;
        @(negedge clk_i);
        prof_wr_en_i   = 1'b0;
        tbl[p][w]      = d;
    endtask

    // Builds the expected per-cycle trace of a sequence, then applies start and compares cycle by cycle.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t q [$];
        exp_t e;
        int   n, p, k;
        int   dw [4];
        dw[0] = v.d0; dw[1] = v.d1; dw[2] = v.d2; dw[3] = v.d3;
        for (int i = 0; i < NP; i++) wr(i, 6, 32'(dw[i]));
        n     = (v.n > NP) ? NP : v.n;
        e     = '0;
        e.act = act_now;
        if (n == 0) begin
            repeat (3) q.push_back(e);
        end else begin
            p = 0;
            while (q.size() < 200) begin
                e.busy = 1'b1;
                q.push_back(e);
                e.cfg = prof_cfg(p);
                e.act = 2'(p);
                repeat ((dw[p] == 0) ? 1 : dw[p]) q.push_back(e);
                e.cfg[0][ENABLE_BIT] = 1'b0;
                repeat (GAP) q.push_back(e);
                if (p < n - 1) p++;
                else if (v.lp) p = 0;
                else begin
                    e.cfg  = '0;
                    e.busy = 1'b0;
                    e.done = 1'b1;
                    q.push_back(e);
                    e.done = 1'b0;
                    q.push_back(e);
                    break;
                end
            end
        end
        if (v.stop_at > 0) begin
            while (q.size() > v.stop_at) void'(q.pop_back());
            e      = q[q.size()-1];
            e.cfg  = '0;
            e.busy = 1'b0;
            e.done = 1'b0;
            q.push_back(e);
        end
        foreach (q[j]) sb.push_back(q[j]);
        act_now        = q[q.size()-1].act;
        start_i        = 1'b1;
        loop_i         = v.lp;
        num_profiles_i = 3'(v.n);
        @(negedge clk_i);
        start_i        = 1'b0;
        loop_i         = !v.lp;
        num_profiles_i = 3'd1;
        k = 0;
        while (sb.size() > 0) begin
            chk($sformatf("vec%0d_cyc%0d", idx, k), obs(), sb.pop_front());
            k++;
            if (v.stop_at != 0 && k == v.stop_at) stop_i = 1'b1;
            @(negedge clk_i);
            stop_i = 1'b0;
        end
    endtask

    initial begin
        resetn_i       = 1'b0;
        prof_wr_en_i   = 1'b0;
        prof_wr_addr_i = '0;
        prof_wr_data_i = '0;
        start_i        = 1'b0;
        stop_i         = 1'b0;
        loop_i         = 1'b0;
        num_profiles_i = '0;
        act_now        = '0;
        for (int p = 0; p < NP; p++) for (int w = 0; w < 7; w++) tbl[p][w] = '0;
        vt[0] = '{2, 1'b0, 0,  5, 3, 0, 0};
        vt[1] = '{2, 1'b1, 30, 5, 3, 0, 0};
        vt[2] = '{1, 1'b0, 0,  0, 4, 0, 0};
        vt[3] = '{0, 1'b0, 0,  2, 2, 2, 2};
        vt[4] = '{7, 1'b0, 0,  2, 1, 3, 2};
        vt[5] = '{3, 1'b0, 0,  1, 1, 1, 0};
        vt[6] = '{1, 1'b0, 0,  0, 0, 0, 0};
        repeat (2) @(negedge clk_i);
        resetn_i = 1'b1;
        chk("reset_outputs", obs(), '0);
        chk1("reset_wr_err", 32'(wr_err_o), 32'd0);
        for (int p = 0; p < NP; p++)
            for (int w = 0; w < 6; w++)
                wr(p, w, (w == 0) ? ((p == 0) ? 32'h1 : 32'h100 * p) : (32'hC0DE_0000 | 32'(p << 4) | 32'(w)));
        for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

        // write protection of the active profile
        wr(0, 6, 5);
        wr(1, 6, 3);
        start_i = 1'b1; loop_i = 1'b1; num_profiles_i = 3'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (11) @(negedge clk_i);
        chk1("prot_active_is_1", 32'(active_profile_o), 32'd1);
        prof_wr_en_i = 1'b1; prof_wr_addr_i = {2'd1, 3'd3}; prof_wr_data_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        prof_wr_addr_i = {2'd0, 3'd3}; prof_wr_data_i = 32'h1234_5678;
        chk1("prot_err_set", 32'(wr_err_o), 32'd1);
        @(negedge clk_i);
        prof_wr_en_i = 1'b0;
        chk1("prot_err_sticky", 32'(wr_err_o), 32'd1);
        repeat (6) @(negedge clk_i);
        chk1("prot_p0_written", config_reg_3_o, 32'h1234_5678);
        chk1("prot_p0_active", 32'(active_profile_o), 32'd0);
        repeat (10) @(negedge clk_i);
        chk1("prot_p1_unchanged", config_reg_3_o, tbl[1][3]);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        chk1("prot_stop_idle", {config_reg_0_o[30:0], busy_o}, 32'd0);
        chk1("prot_stop_no_done", 32'(seq_done_o), 32'd0);
        chk1("prot_err_after_stop", 32'(wr_err_o), 32'd1);
        tbl[0][3] = 32'h1234_5678;
        start_i = 1'b1; loop_i = 1'b0; num_profiles_i = 3'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk1("prot_err_cleared", 32'(wr_err_o), 32'd0);
        repeat (12) @(negedge clk_i);
        chk1("prot_run_finished", 32'(busy_o), 32'd0);
        act_now = 2'd0;

        // asynchronous reset mid-RUN clears outputs at once and wipes the table
        wr(0, 6, 10);
        start_i = 1'b1; num_profiles_i = 3'd1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk1("async_pre_busy", 32'(busy_o), 32'd1);
        #2 resetn_i = 1'b0;
        #1 chk("async_reset_outputs", obs(), '0);
        chk1("async_reset_err", 32'(wr_err_o), 32'd0);
        @(negedge clk_i);
        resetn_i = 1'b1;
        for (int p = 0; p < NP; p++) for (int w = 0; w < 7; w++) tbl[p][w] = '0;
        act_now = '0;
        run_vec(6, vt[6]);

        // stop wins over a simultaneous start
        start_i = 1'b1; stop_i = 1'b1; num_profiles_i = 3'd2;
        @(negedge clk_i);
        start_i = 1'b0; stop_i = 1'b0;
        repeat (3) begin
            chk("start_stop_idle", obs(), '{cfg: '0, busy: 1'b0, done: 1'b0, act: act_now});
            @(negedge clk_i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
